board_eval: RTL and testbench

- Avalon-MM accelerator that consumes the child boards written to SDRAM by the move generators.
- It reads N consecutive 64-square boards, computes a signed material score for each, and reports the best score and the index of the board that produced it.
- CPU-facing slave for configuration and results; SDRAM-facing master that only reads, one outstanding read at a time.

---
 rtl/board_eval.sv | 162 ++++++++++++++++
 tb/tb_board_eval.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/board_eval.sv
// Scores N boards read from SDRAM and reports the best score and its board index.
// Latency: 129*N+1 cycles with zero-wait one-cycle-latency memory; one read in flight; master honours waitrequest.
module board_eval #(
  parameter int MAX_BOARDS = 255,
  parameter int SQ_STRIDE  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        slave_waitrequest,
  input  logic [3:0]  slave_address,
  input  logic        slave_read,
  output logic [31:0] slave_readdata,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  input  logic        master_waitrequest,
  output logic [31:0] master_address,
  output logic        master_read,
  input  logic [31:0] master_readdata,
  input  logic        master_readdatavalid,
  output logic        master_write,
  output logic [31:0] master_writedata
);

  typedef enum logic [2:0] {IDLE, RD_SQ, WT_SQ, CMP, DONE} state_t;

  localparam logic [31:0] SQ_STR  = 32'(SQ_STRIDE);
  localparam logic [31:0] BRD_STR = 32'(64 * SQ_STRIDE);
  localparam logic [31:0] MAX_CNT = 32'(MAX_BOARDS);

  state_t             state, state_nxt;
  logic [31:0]        base;
  logic [7:0]         count;
  logic               mode;
  logic signed [31:0] best_score;
  logic [7:0]         best_idx;
  logic               done;
  logic [7:0]         board;
  logic [5:0]         sq;
  logic signed [31:0] acc;
  logic               first;
  logic               busy, start, take, last_board;
  logic signed [31:0] sq_val;
  logic               unused_ok;

  function automatic logic signed [31:0] piece_value(input logic [7:0] code);
    logic [7:0]         mag;
    logic signed [31:0] v;
    mag = code[7] ? (8'd0 - code) : code;
    case (mag)
      8'd1:    v = 32'sd100;
      8'd2:    v = 32'sd320;
      8'd3:    v = 32'sd330;
      8'd4:    v = 32'sd500;
      8'd5:    v = 32'sd900;
      8'd6:    v = 32'sd20000;
      default: v = 32'sd0;
    endcase
    return code[7] ? -v : v;
  endfunction

  assign slave_waitrequest = 1'b0;
  assign master_write      = 1'b0;
  assign master_writedata  = 32'd0;
  assign unused_ok         = ^{slave_read, master_readdata[31:8]};

  assign busy       = (state == RD_SQ) || (state == WT_SQ) || (state == CMP);
  assign start      = slave_write && (slave_address == 4'd0) && !busy;
  assign sq_val     = piece_value(master_readdata[7:0]);
  assign last_board = ((board + 8'd1) == count);
  assign take       = !first || (mode ? (acc > best_score) : (acc < best_score));

  assign master_read    = (state == RD_SQ);
  assign master_address = (state == RD_SQ) ? base + 32'(board) * BRD_STR + 32'(sq) * SQ_STR : 32'd0;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = (count == 8'd0) ? DONE : RD_SQ;
      RD_SQ:      if (!master_waitrequest) state_nxt = WT_SQ;
      WT_SQ:      if (master_readdatavalid) state_nxt = (sq == 6'd63) ? CMP : RD_SQ;
      CMP:        state_nxt = last_board ? DONE : RD_SQ;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base       <= 32'd0;
      count      <= 8'd0;
      mode       <= 1'b0;
      best_score <= 32'sd0;
      best_idx   <= 8'd0;
      done       <= 1'b0;
      board      <= 8'd0;
      sq         <= 6'd0;
      acc        <= 32'sd0;
      first      <= 1'b0;
    end else begin
      if (slave_write && !busy) begin
        case (slave_address)
          4'd1: base  <= slave_writedata;
          4'd2: count <= (slave_writedata > MAX_CNT) ? MAX_CNT[7:0] : slave_writedata[7:0];
          4'd3: mode  <= slave_writedata[0];
          default: ;
        endcase
      end
      case (state)
        IDLE, DONE: begin
          if (start) begin
            done  <= (count == 8'd0);
            board <= 8'd0;
            sq    <= 6'd0;
            acc   <= 32'sd0;
            first <= 1'b0;
            if (count == 8'd0) begin
              best_score <= 32'sd0;
              best_idx   <= 8'd0;
            end
          end
        end
        WT_SQ: begin
          if (master_readdatavalid) begin
            acc <= acc + sq_val;
            if (sq != 6'd63) sq <= sq + 6'd1;
          end
        end
        CMP: begin
          // Strict compare keeps the earlier board on a tie.
          if (take) begin
            best_score <= acc;
            best_idx   <= board;
            first      <= 1'b1;
          end
          acc   <= 32'sd0;
          sq    <= 6'd0;
          board <= board + 8'd1;
          if (last_board) done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    slave_readdata = 32'd0;
    case (slave_address)
      4'd0: slave_readdata = {30'd0, busy, done};
      4'd1: slave_readdata = base;
      4'd2: slave_readdata = {24'd0, count};
      4'd3: slave_readdata = {31'd0, mode};
      4'd4: slave_readdata = best_score;
      4'd5: slave_readdata = {24'd0, best_idx};
      default: ;
    endcase
  end

endmodule

// File: tb/tb_board_eval.sv
// Directed bench for board_eval with a single-outstanding SDRAM responder model.
module tb_board_eval;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        slave_waitrequest;
  logic [3:0]  slave_address = 4'd0;
  logic        slave_read = 1'b0;
  logic [31:0] slave_readdata;
  logic        slave_write = 1'b0;
  logic [31:0] slave_writedata = 32'd0;
  logic        master_waitrequest;
  logic [31:0] master_address;
  logic        master_read;
  logic [31:0] master_readdata;
  logic        master_readdatavalid;
  logic        master_write;
  logic [31:0] master_writedata;

  int vectors = 0;
  int errs = 0;

  logic [7:0]  mem [0:1023];
  int          stall_cfg = 0;
  int          lat_cfg = 1;
  logic        clr_model = 1'b1;
  logic [31:0] base_cfg = 32'd0;
  int          reads, stall_cnt, addr_err, pend_cnt;
  logic [7:0]  pend_data;

  always #5 clk = ~clk;

  board_eval dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .slave_waitrequest    (slave_waitrequest),
    .slave_address        (slave_address),
    .slave_read           (slave_read),
    .slave_readdata       (slave_readdata),
    .slave_write          (slave_write),
    .slave_writedata      (slave_writedata),
    .master_waitrequest   (master_waitrequest),
    .master_address       (master_address),
    .master_read          (master_read),
    .master_readdata      (master_readdata),
    .master_readdatavalid (master_readdatavalid),
    .master_write         (master_write),
    .master_writedata     (master_writedata)
  );

  function automatic logic [7:0] mem_at(input logic [31:0] a);
    logic [31:0] idx;
    idx = (a - 32'h4000) >> 2;
    if (idx < 32'd1024) return mem[idx[9:0]];
    return 8'h00;
  endfunction

  // Only the first read of a run is stalled / delayed; junk in the upper data bits.
  assign master_waitrequest = master_read && (reads == 0) && (stall_cnt < stall_cfg);

  always @(posedge clk) begin
    master_readdatavalid <= 1'b0;
    if (clr_model) begin
      reads     <= 0;
      stall_cnt <= 0;
      addr_err  <= 0;
      pend_cnt  <= 0;
    end else begin
      if (pend_cnt != 0) begin
        pend_cnt <= pend_cnt - 1;
        if (pend_cnt == 1) begin
          master_readdatavalid <= 1'b1;
          master_readdata      <= {24'h5A5A5A, pend_data};
        end
      end
      if (master_read) begin
        if (master_address !== base_cfg + 32'(reads) * 32'd4) addr_err <= addr_err + 1;
        if (master_waitrequest) stall_cnt <= stall_cnt + 1;
        else begin
          reads <= reads + 1;
          if (reads == 0 && lat_cfg > 1) begin
            pend_cnt  <= lat_cfg - 1;
            pend_data <= mem_at(master_address);
          end else begin
            master_readdatavalid <= 1'b1;
            master_readdata      <= {24'h5A5A5A, mem_at(master_address)};
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d (0x%h) expected %0d (0x%h)", tag, $signed(obs), obs, $signed(exp), exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    slave_address   = a;
    slave_writedata = d;
    slave_write     = 1'b1;
    @(posedge clk); #1;
    slave_write     = 1'b0;
    slave_address   = 4'd0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    slave_address = a;
    slave_read    = 1'b1;
    #1;
    d             = slave_readdata;
    slave_read    = 1'b0;
    slave_address = 4'd0;
  endtask

  task automatic run(input string tag, input logic [31:0] b, input logic [7:0] n, input logic m,
                     output int cyc);
    logic [31:0] st;
    base_cfg = b;
    wr(4'd1, b);
    wr(4'd2, {24'd0, n});
    clr_model = 1'b1;
    wr(4'd3, {31'd0, m});
    clr_model = 1'b0;
    wr(4'd0, 32'd0);
    cyc = 1;
    rd(4'd0, st);
    check({tag, "_status_after_start"}, st, (n == 8'd0) ? 32'd1 : 32'd2);
    slave_address = 4'd0;
    while (slave_readdata[0] !== 1'b1 && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  initial begin
    int          cyc;
    int          k;
    logic [31:0] d;

    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[28] = 8'h05; mem[52] = 8'hFF;                       // 0x4000: 900-100
    mem[64] = 8'h01; mem[74] = 8'h03; mem[75] = 8'hFD;      // 0x4100: 100
    mem[191] = 8'h05;                                       // 0x4200: 900
    mem[192] = 8'h04;
    for (int i = 200; i < 204; i++) mem[i] = 8'h01;         // 0x4300: 500+400
    mem[256] = 8'h07; mem[300] = 8'hF7; mem[319] = 8'h80;   // 0x4400: all worth 0
    for (int i = 320; i < 384; i++) mem[i] = 8'hFA;         // 0x4500: 64 black kings

    repeat (3) @(posedge clk);
    #1;
    check("rst_master_read", {31'd0, master_read}, 32'd0);
    check("rst_master_addr", master_address, 32'd0);
    check("rst_master_write", {31'd0, master_write}, 32'd0);
    check("rst_slave_wait", {31'd0, slave_waitrequest}, 32'd0);
    for (int a = 0; a < 7; a++) begin
      rd(a[3:0], d);
      check($sformatf("rst_reg%0d", a), d, 32'd0);
    end
    rst_n = 1'b1;
    clr_model = 1'b0;
    @(posedge clk); #1;

    run("cnt0", 32'h4000, 8'd0, 1'b1, cyc);
    check("cnt0_cycles", 32'(cyc), 32'd1);
    rd(4'd4, d); check("cnt0_score", d, 32'd0);
    rd(4'd5, d); check("cnt0_idx", d, 32'd0);
    check("cnt0_reads", 32'(reads), 32'd0);

    run("one", 32'h4000, 8'd1, 1'b1, cyc);
    check("one_cycles", 32'(cyc), 32'd130);
    rd(4'd4, d); check("one_score", d, 32'd800);
    rd(4'd5, d); check("one_idx", d, 32'd0);
    check("one_reads", 32'(reads), 32'd64);
    check("one_addr_err", 32'(addr_err), 32'd0);

    run("max3", 32'h4100, 8'd3, 1'b1, cyc);
    check("max3_cycles", 32'(cyc), 32'd388);
    rd(4'd4, d); check("max3_score", d, 32'd900);
    rd(4'd5, d); check("max3_idx", d, 32'd1);
    check("max3_addr_err", 32'(addr_err), 32'd0);

    run("min3", 32'h4100, 8'd3, 1'b0, cyc);
    rd(4'd4, d); check("min3_score", d, 32'd100);
    rd(4'd5, d); check("min3_idx", d, 32'd0);
    check("min3_reads", 32'(reads), 32'd192);

    stall_cfg = 3;
    lat_cfg   = 4;
    run("stall", 32'h4000, 8'd1, 1'b1, cyc);
    check("stall_cycles", 32'(cyc), 32'd136);
    check("stall_seen", 32'(stall_cnt), 32'd3);
    check("stall_addr_err", 32'(addr_err), 32'd0);
    rd(4'd4, d); check("stall_score", d, 32'd800);
    stall_cfg = 0;
    lat_cfg   = 1;

    run("junk", 32'h4400, 8'd1, 1'b1, cyc);
    rd(4'd4, d); check("junk_score", d, 32'd0);

    run("kings", 32'h4500, 8'd1, 1'b1, cyc);
    rd(4'd4, d); check("kings_score", d, -32'sd1280000);

    wr(4'd2, 32'd300);
    rd(4'd2, d); check("count_saturate", d, 32'd255);

    // Abort a run part-way through board 1.
    base_cfg = 32'h4100;
    wr(4'd1, 32'h4100);
    wr(4'd2, 32'd3);
    clr_model = 1'b1;
    wr(4'd3, 32'd1);
    clr_model = 1'b0;
    wr(4'd0, 32'd0);
    wr(4'd1, 32'hDEAD0000);
    rd(4'd1, d); check("busy_write_ignored", d, 32'h4100);
    k = 0;
    while (!(master_read === 1'b1 && master_address === 32'h4278) && k < 1000) begin
      @(posedge clk); #1;
      k++;
    end
    check("abort_reached_b1s30", {31'd0, master_read}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_master_read", {31'd0, master_read}, 32'd0);
    check("abort_master_addr", master_address, 32'd0);
    rd(4'd0, d); check("abort_status", d, 32'd0);
    rd(4'd1, d); check("abort_base", d, 32'd0);
    rd(4'd4, d); check("abort_score", d, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run("rerun", 32'h4100, 8'd3, 1'b0, cyc);
    check("rerun_cycles", 32'(cyc), 32'd388);
    rd(4'd4, d); check("rerun_score", d, 32'd100);
    rd(4'd5, d); check("rerun_idx", d, 32'd0);
    check("rerun_addr_err", 32'(addr_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
